// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing that bridges bus transfers onto a byte-wide
// register-file port using a pointer with auto-increment; runs entirely on clk.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] rx_sh, rx_n, tx_sh, tx_n, rx_byte;
  logic       rw, rw_n, load_pend, load_n;
  logic       sda_oe_n, we_n, re_n, busy_n;
  logic [7:0] addr_n, wdata_n;

  // Synchronizers preset to 1 so a reset looks like an idle bus, not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {rx_sh[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      rw        <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_sh     <= rx_n;
      tx_sh     <= tx_n;
      rw        <= rw_n;
      load_pend <= load_n;
      sda_oe    <= sda_oe_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      busy      <= busy_n;
    end
  end

  // In the ACK states sda_oe doubles as the phase flag: the first SCL fall
  // starts driving the ACK, the second one ends the ACK slot.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx_sh;
    tx_n      = tx_sh;
    rw_n      = rw;
    load_n    = reg_re;
    sda_oe_n  = sda_oe;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;
    we_n      = 1'b0;
    re_n      = 1'b0;
    busy_n    = busy;

    if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      load_n    = 1'b0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      load_n    = 1'b0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_n      = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                rw_n    = rx_byte[0];
                state_n = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
              end else if (state == PTR) begin
                addr_n  = rx_byte;
                state_n = PTR_ACK;
              end else begin
                wdata_n = rx_byte;
                we_n    = 1'b1;
                state_n = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 3'd0;
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              re_n    = 1'b1;
              state_n = RDATA;
            end else begin
              sda_oe_n = 1'b0;
              if (state == WDATA_ACK)
                addr_n = reg_addr + 8'd1;
              state_n = (state == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          if (load_pend) begin
            tx_n     = reg_rdata;
            sda_oe_n = ~reg_rdata[7];
          end else if (scl_fall) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              tx_n     = {tx_sh[6:0], 1'b0};
              sda_oe_n = ~tx_sh[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && sda_s) begin
            state_n = IGNORE;
          end else if (scl_fall) begin
            addr_n    = reg_addr + 8'd1;
            re_n      = 1'b1;
            bit_cnt_n = 3'd0;
            state_n   = RDATA;
          end
        end
        IGNORE: sda_oe_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers an external controller on SCL/SDA. It bridges bus transactions to a byte-wide register-file interface.
- Supports 7-bit addressing, an 8-bit register pointer with auto-increment, multi-byte writes and reads, and repeated START.
- Sits between the chip pads (open-drain SDA) and a local register bank, clocked by the fast system clock (not by SCL).

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address this block answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (legal values 2..4).

Ports:
- clk  in  1  system clock; must be ≥ 16x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad is open-drain).
- reg_addr  out  8  register pointer for the current access.
- reg_wdata  out  8  write data; valid while reg_we=1.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read strobe.
- reg_rdata  in  8  read data; must be valid exactly 1 clk after reg_re.
- busy  out  1  high from a detected START to a detected STOP.

Behaviour:
- Reset (async, rst_n=0): sda_oe=0, reg_we=0, reg_re=0, reg_addr=0x00, reg_wdata=0x00, busy=0, state=IDLE, synchronizers preset to 1 (bus idle). Pointer survives STOP; only reset clears it.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals against a 1-clk delayed copy.
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - START/STOP take priority over any state and abort the current byte without issuing strobes.
- Bit timing:
  - Receive bits are sampled on the SCL rising edge, MSB first.
  - The target changes sda_oe only on the clk after an SCL falling edge is detected, never while SCL is high.
- Bit counter runs 0..7 per byte, plus the ACK slot as the 9th SCL pulse.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE --START--> ADDR. Any state --START--> ADDR (repeated start); busy stays 1.
- ADDR, after 8 bits:
  - Address match → ADDR_ACK; sda_oe=1 for the 9th SCL pulse.
  - Mismatch → IGNORE; sda_oe stays 0 until START/STOP.
- ADDR_ACK, at SCL falling edge ending the ACK:
  - R/W=0 → PTR.
  - R/W=1 → reg_re pulses. On the next clk, reg_rdata loads into the TX shifter and bit 7 drives sda_oe=~bit → RDATA.
- PTR, after 8 bits: reg_addr=byte → PTR_ACK (ACK driven) → WDATA.
- WDATA, after 8 bits:
  - reg_wdata=byte, reg_we pulses for 1 clk at the SCL rising edge of bit 0, with reg_addr = current pointer.
  - Go to WDATA_ACK (ACK driven). At the end of the ACK slot, reg_addr increments mod 256 (0xFF → 0x00), then → WDATA.
- RDATA: shift out 8 bits, then release SDA → RDATA_ACK. Sample the controller's ACK on the SCL rising edge.
  - ACK (0): reg_addr increments mod 256; reg_re at the SCL falling edge; load the next byte → RDATA.
  - NACK (1): → IGNORE, SDA released.
- STOP in any state → IDLE, sda_oe=0, busy=0.
- A STOP before the 8th bit of WDATA discards the partial byte: no reg_we, pointer unchanged.
- reg_we and reg_re are never asserted in the same clk.

Test Plan:
- Write: START, 0x84 (0x42+W), ptr 0x10, data 0xA5, 0x5A, STOP → target ACKs all 4 bytes; reg_we pulses with (0x10,0xA5) then (0x11,0x5A); final reg_addr=0x12; busy drops after STOP.
- Combined read: START, 0x84, ptr 0x20, repeated START, 0x85, read 3 bytes (ACK, ACK, NACK), STOP, with regfile[n]=n^0xFF → SDA carries 0xDF, 0xDE, 0xDD; reg_re pulses 3 times at addresses 0x20/0x21/0x22; SDA released after the NACK.
- Address mismatch: START, 0x86 (0x43+W), 2 bytes, STOP → sda_oe never asserts; no reg_we/reg_re.
- Wrap: write ptr 0xFF with data 0x11, 0x22 → writes land at 0xFF then 0x00.
- Abort: START, 0x84, ptr 0x05, 4 data bits, STOP → no reg_we; next write of 0x33 lands at 0x05.
- Reset mid-read: rst_n low while sda_oe=1 → sda_oe=0 in the same clk, busy=0, reg_addr=0x00; next full write transaction succeeds.
